// File: rtl/prol16_fetch_unit.sv
// prol16_fetch_unit: instruction prefetch stage for the Prol16 model.
// Wishbone classic-cycle read master that streams consecutive 16-bit words
// from the fetch pointer into a small FIFO of {data, pc} entries. The FIFO
// head is presented to the core over a valid/ready handshake. A flush
// empties the FIFO and redirects fetching to flush_pc.
// Optional ack watchdog: define PROL16_FETCH_TIMEOUT_EN.
module prol16_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              instr_valid,
  output logic [15:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [15:0]       wb_datM,
  output logic [1:0]        wb_sel,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  input  logic [15:0]       wb_datS,
  input  logic              wb_ack,
  output logic              fetch_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  typedef struct packed {
    logic [15:0]       data;
    logic [ADDR_W-1:0] pc;
  } fifo_ent_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [ADDR_W-1:0]     adr_q, adr_d;
  logic                  cyc_q, cyc_d;

  fifo_ent_t [DEPTH-1:0] fifo_q;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_eff;

  logic                  pop, push;
  logic                  room_now, room_after;
  logic                  busy, tmo_hit, halted;
  logic [ADDR_W-1:0]     pc_inc;

  // Head of the FIFO drives the consumer directly from registers.
  assign instr_valid = (count != '0);
  assign instr_data  = fifo_q[rd_ptr].data;
  assign instr_pc    = fifo_q[rd_ptr].pc;

  // Flush wins over a pop in the same cycle.
  assign pop       = instr_valid & instr_ready & ~flush;
  assign count_eff = count - CNT_W'(pop);
  // room_now: a slot is free once this cycle's pop is taken into account.
  // room_after: still a slot free after also writing the word acked now.
  assign room_now   = count_eff < CNT_W'(DEPTH);
  assign room_after = count_eff < CNT_W'(DEPTH - 1);

  assign pc_inc = pc_q + ADDR_W'(1);
  assign busy   = (state_q == FETCH) || (state_q == DISCARD);

  // Read-only master: fixed write-side signals, strobe tracks cycle.
  assign wb_adr  = adr_q;
  assign wb_cyc  = cyc_q;
  assign wb_stb  = cyc_q;
  assign wb_we   = 1'b0;
  assign wb_sel  = 2'b11;
  assign wb_datM = '0;

`ifdef PROL16_FETCH_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q, halt_q;

  // Ack watchdog: counts unacked bus cycles, error is sticky until reset,
  // fetching stays parked until the next flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      if (busy && !wb_ack && !tmo_hit) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                             tmo_cnt <= '0;
      if (tmo_hit) err_q <= 1'b1;
      if (flush)        halt_q <= 1'b0;
      else if (tmo_hit) halt_q <= 1'b1;
    end
  end

  assign halted    = halt_q;
  assign fetch_err = err_q;
`else
  localparam bit TMO_EN = 1'b0;
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_cnt   = '0;
  assign halted    = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign tmo_hit = TMO_EN && busy && !wb_ack && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, next fetch pointer and bus request; push marks a kept word.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    adr_d   = adr_q;
    cyc_d   = cyc_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          pc_d = flush_pc;
        end else if (room_now && !halted) begin
          state_d = FETCH;
          adr_d   = pc_q;
          cyc_d   = 1'b1;
        end
      end
      FETCH: begin
        if (flush) begin
          pc_d = flush_pc;
          // Acked word is dropped; the emptied FIFO lets the redirected
          // request go out immediately. Without ack the cycle must run out.
          if (wb_ack) adr_d = flush_pc;
          else        state_d = DISCARD;
        end else if (wb_ack) begin
          push = 1'b1;
          pc_d = pc_inc;
          if (room_after) begin
            adr_d = pc_inc;
          end else begin
            state_d = IDLE;
            cyc_d   = 1'b0;
          end
        end
      end
      DISCARD: begin
        if (wb_ack) begin
          if (flush) begin
            pc_d    = flush_pc;
            adr_d   = flush_pc;
            state_d = FETCH;
          end else if (room_now) begin
            adr_d   = pc_q;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
            cyc_d   = 1'b0;
          end
        end else if (flush) begin
          pc_d = flush_pc;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
    // Watchdog expiry abandons the bus cycle regardless of state.
    if (tmo_hit) begin
      state_d = IDLE;
      cyc_d   = 1'b0;
      push    = 1'b0;
    end
  end

  // Fetch pointer and registered Wishbone request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      adr_q <= RESET_PC;
      cyc_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      adr_q <= adr_d;
      cyc_q <= cyc_d;
    end
  end

  // Prefetch FIFO: flush empties it, push and pop may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= {wb_datS, adr_q};
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_prol16_fetch_unit.sv
// tb_prol16_fetch_unit: directed table, corner sequences and a randomized
// run against a stream-level model of the fetch unit.
module tb_prol16_fetch_unit;

  localparam logic [15:0] RPC = 16'h0010;

  logic        clk, rst, flush, instr_ready;
  logic [15:0] flush_pc;
  logic        instr_valid;
  logic [15:0] instr_data, instr_pc;
  logic [15:0] wb_adr, wb_datM, wb_datS;
  logic [1:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, fetch_err;

  int n_chk  = 0;
  int n_fail = 0;

  prol16_fetch_unit #(.ADDR_W(16), .DEPTH(4), .RESET_PC(RPC), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .wb_adr(wb_adr), .wb_datM(wb_datM),
    .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_datS(wb_datS), .wb_ack(wb_ack), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: word k holds A000+k.
  function automatic logic [15:0] ram(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // Wishbone slave with a programmable or random number of wait states.
  logic       ack_en = 1'b1;
  logic       rand_ws = 1'b0;
  logic [1:0] fixed_ws = 2'd0;
  logic [1:0] ws_target = 2'd0;
  logic [3:0] ws_cnt = 4'd0;

  assign wb_ack  = wb_cyc & wb_stb & ack_en & (ws_cnt == {2'b00, ws_target});
  assign wb_datS = ram(wb_adr);

  always @(posedge clk) begin
    if (!wb_cyc || wb_ack) begin
      ws_cnt    <= 4'd0;
      ws_target <= rand_ws ? 2'($urandom_range(0, 3)) : fixed_ws;
    end else if (ws_cnt != 4'hF) begin
      ws_cnt <= ws_cnt + 4'd1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hold reset for two cycles, check reset values, release on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bus", {wb_cyc, wb_stb, wb_we, wb_sel, wb_datM, wb_adr},
        {1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, RPC});
    chk("rst_instr", {instr_valid, instr_data, instr_pc, fetch_err}, 34'h0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [15:0] data;
    logic [15:0] pc;
    logic        cyc;
    logic [15:0] adr;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  initial begin
    int          n;
    logic        seen;
    logic [15:0] exp_pc;
    logic        prev_cyc, prev_ack, prev_flush;
    logic [15:0] prev_adr;
    int          pops;

    // Zero-wait RAM, one row per cycle after reset release.
    vec[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0010};
    vec[1]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010};
    vec[2]  = '{1'b1, 1'b1, 16'hA010, 16'h0010, 1'b1, 16'h0011};
    vec[3]  = '{1'b1, 1'b1, 16'hA011, 16'h0011, 1'b1, 16'h0012};
    vec[4]  = '{1'b0, 1'b1, 16'hA012, 16'h0012, 1'b1, 16'h0013};
    vec[5]  = '{1'b0, 1'b1, 16'hA012, 16'h0012, 1'b1, 16'h0014};
    vec[6]  = '{1'b0, 1'b1, 16'hA012, 16'h0012, 1'b1, 16'h0015};
    vec[7]  = '{1'b0, 1'b1, 16'hA012, 16'h0012, 1'b0, 16'h0000};
    vec[8]  = '{1'b1, 1'b1, 16'hA012, 16'h0012, 1'b0, 16'h0000};
    vec[9]  = '{1'b0, 1'b1, 16'hA013, 16'h0013, 1'b1, 16'h0016};
    vec[10] = '{1'b0, 1'b1, 16'hA013, 16'h0013, 1'b0, 16'h0000};
    vec[11] = '{1'b1, 1'b1, 16'hA013, 16'h0013, 1'b0, 16'h0000};
    vec[12] = '{1'b1, 1'b1, 16'hA014, 16'h0014, 1'b1, 16'h0017};
    vec[13] = '{1'b1, 1'b1, 16'hA015, 16'h0015, 1'b1, 16'h0018};
    vec[14] = '{1'b0, 1'b1, 16'hA016, 16'h0016, 1'b1, 16'h0019};

    rst = 1'b1;
    flush = 1'b0;
    flush_pc = 16'h0;
    instr_ready = 1'b0;

    // ---- table: streaming, fill to DEPTH, single-pop refill
    do_reset();
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("tbl%0d_vld", i), instr_valid, vec[i].vld);
      chk($sformatf("tbl%0d_cyc", i), {wb_cyc, wb_stb, wb_we, wb_sel}, {vec[i].cyc, vec[i].cyc, 1'b0, 2'b11});
      if (vec[i].cyc) chk($sformatf("tbl%0d_adr", i), wb_adr, vec[i].adr);
      if (vec[i].vld) chk($sformatf("tbl%0d_head", i), {instr_data, instr_pc}, {vec[i].data, vec[i].pc});
      instr_ready = vec[i].rdy;
      if (i != NV - 1) @(negedge clk);
    end

    // ---- asynchronous reset in the middle of a bus cycle
    rst = 1'b1;
    #1;
    chk("async_rst", {wb_cyc, wb_stb, instr_valid}, 3'b000);

    // ---- 3 wait states, flush during the 2nd wait cycle
    fixed_ws = 2'd3;
    do_reset();
    @(negedge clk);
    chk("ws3_req", {wb_cyc, wb_adr}, {1'b1, RPC});
    @(negedge clk);
    flush = 1'b1;
    flush_pc = 16'h0200;
    @(negedge clk);
    flush = 1'b0;
    chk("ws3_hold", {wb_cyc, wb_stb, wb_adr, instr_valid}, {1'b1, 1'b1, RPC, 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (instr_valid) seen = 1'b1;
      else @(negedge clk);
    end
    chk("ws3_seen", seen, 1'b1);
    chk("ws3_head", {instr_data, instr_pc}, {ram(16'h0200), 16'h0200});

    // ---- flush coinciding with a pop and an ack
    fixed_ws = 2'd0;
    do_reset();
    instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("fpa_pre", {instr_valid, wb_cyc, wb_ack}, 3'b111);
    flush = 1'b1;
    flush_pc = 16'h0300;
    @(negedge clk);
    flush = 1'b0;
    chk("fpa_empty", instr_valid, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (instr_valid) seen = 1'b1;
      else @(negedge clk);
    end
    chk("fpa_seen", seen, 1'b1);
    chk("fpa_head", {instr_data, instr_pc}, {ram(16'h0300), 16'h0300});

    // ---- ack that never arrives
    ack_en = 1'b0;
    do_reset();
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (wb_cyc) n++;
    end
`ifdef PROL16_FETCH_TIMEOUT_EN
    chk("tmo_cycles", n, 15);
    chk("tmo_err", {fetch_err, wb_cyc}, 2'b10);
`else
    chk("tmo_cycles", n, 40);
    chk("tmo_err", {fetch_err, wb_cyc}, 2'b01);
`endif
    ack_en = 1'b1;

    // ---- randomized run against the stream model
    rand_ws = 1'b1;
    do_reset();
    exp_pc = RPC;
    prev_cyc = 1'b0;
    prev_ack = 1'b0;
    prev_adr = 16'h0;
    prev_flush = 1'b0;
    pops = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_proto", {wb_stb, wb_we, wb_sel, wb_datM}, {wb_cyc, 1'b0, 2'b11, 16'h0000});
      if (prev_cyc && !prev_ack)
        chk("rnd_hold", {wb_cyc, wb_adr}, {1'b1, prev_adr});
      if (prev_flush) chk("rnd_flush_drop", instr_valid, 1'b0);
      if (instr_valid)
        chk("rnd_head", {instr_pc, instr_data}, {exp_pc, ram(exp_pc)});
      instr_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      flush_pc = 16'($urandom);
      #1;
      prev_cyc = wb_cyc;
      prev_ack = wb_ack;
      prev_adr = wb_adr;
      prev_flush = flush;
      if (flush) begin
        exp_pc = flush_pc;
      end else if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 16'd1;
        pops++;
      end
    end
    flush = 1'b0;
    chk("rnd_progress", (pops >= 300), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prol16_fetch_unit.md
# prol16_fetch_unit

Instruction prefetch stage for the Prol16 processor model. Acts as a Wishbone classic-cycle read master toward the RAM slave, fetching consecutive 16-bit instruction words from a program counter into a small prefetch FIFO. Presents them to the core/model via a valid/ready handshake. Supports a flush/redirect for jumps.

## Interface
- `ADDR_W`, 16, Wishbone word-address width
- `DEPTH`, 4, prefetch FIFO entries; power of two, at least 2
- `RESET_PC`, 0, fetch address after reset
- `TIMEOUT`, 15, ack watchdog limit in cycles; only used with the macro
- `clk` in 1: system clock, all logic rising-edge
- `rst` in 1: asynchronous, active-high reset
- `flush` in 1: discard all prefetched or in-flight words and redirect
- `flush_pc` in ADDR_W: new fetch address, sampled when `flush`=1
- `instr_valid` out 1: FIFO head holds a valid instruction
- `instr_data` out 16: instruction word at the FIFO head
- `instr_pc` out ADDR_W: address the head word was fetched from
- `instr_ready` in 1: consumer accepts the head word when `instr_valid` is also 1
- `wb_adr` out ADDR_W: Wishbone address
- `wb_datM` out 16: master write data; constant 0
- `wb_sel` out 2: byte select; constant 2'b11
- `wb_cyc`, `wb_stb` out 1 each: Wishbone cycle and strobe; always driven equal
- `wb_we` out 1: constant 0, read-only master
- `wb_datS` in 16: slave read data
- `wb_ack` in 1: slave acknowledge
- `fetch_err` out 1: sticky watchdog error

## Operation
- Internal fetch pointer `pc`. FIFO holds {data, pc} pairs. Occupancy `count` runs 0..DEPTH.
- A pop occurs when `instr_valid & instr_ready & ~flush`.
- The FSM has three states: IDLE, FETCH and DISCARD.
- IDLE → FETCH when `count - pop < DEPTH` and `flush`=0. On entry, `wb_adr`=`pc` and `wb_cyc`=`wb_stb`=1.
- FETCH on `wb_ack`=1:
  - Write {`wb_datS`, `wb_adr`} into the FIFO and set `pc`=`pc`+1, wrapping mod 2^ADDR_W.
  - If a free slot remains after this write (accounting for a same-cycle pop), stay in FETCH with `wb_adr`=new `pc`. This gives back-to-back strobes.
  - Otherwise deassert `wb_cyc`/`wb_stb` and go to IDLE.
- FETCH with `wb_ack`=0: hold `wb_adr`, `wb_cyc` and `wb_stb` stable.
- `flush` has priority over pop and over fill:
  - FIFO is emptied and `pc`=`flush_pc`.
  - If in FETCH with `wb_ack`=0, go to DISCARD. The cycle stays asserted until ack, because classic cycles are not aborted. The returned data is dropped. Then go to IDLE, or to FETCH at `flush_pc` if space allows.
  - If in FETCH with `wb_ack`=1 in the same cycle, the acked word is dropped and the next request uses `flush_pc`.
  - A flush while in DISCARD updates `pc` again and stays in DISCARD.
- Simultaneous write and pop on a full FIFO is legal; `count` is unchanged.
- Reset mid-cycle: `wb_cyc`/`wb_stb` drop immediately (asynchronous) and the FIFO is cleared.

## Timing
- Reset values:
  - `wb_cyc`=`wb_stb`=`wb_we`=0, `wb_adr`=RESET_PC, `wb_sel`=2'b11, `wb_datM`=0.
  - `instr_valid`=0, `instr_data`=0, `instr_pc`=0, `fetch_err`=0.
  - FSM in IDLE, `pc`=RESET_PC.
- First strobe appears in the first cycle after `rst` deasserts.
- Fetch latency: a word acked at edge N is visible on `instr_*` with `instr_valid`=1 after edge N.
- Peak throughput is 1 word/cycle with a zero-wait slave.
- `instr_valid` drops in the cycle after a flush edge.
- All outputs are registered except `instr_*`, which come from the FIFO head registers with no combinational path from `instr_ready`.

## Configuration
- `PROL16_FETCH_TIMEOUT_EN` defined:
  - A counter runs while in FETCH or DISCARD and resets on each ack.
  - When it reaches TIMEOUT, the unit deasserts `wb_cyc`/`wb_stb`, sets `fetch_err`=1 (cleared only by `rst`), and returns to IDLE. Fetching then stops until `flush` is applied.
- Macro undefined: no counter; `fetch_err` is tied to 0 and the unit waits indefinitely for ack.

## Test plan
- Reset with RESET_PC=16'h0010 → first request has `wb_adr`=0010 and `wb_cyc`=`wb_stb`=1 in the first cycle after reset. `wb_we`=0 and `wb_sel`=2'b11 throughout.
- Zero-wait RAM holding word k = 16'hA000+k, `instr_ready`=1 → consumer sees A010, A011, A012… on consecutive cycles with matching `instr_pc`.
- `instr_ready`=0 → exactly DEPTH=4 words are fetched, then `wb_cyc` drops. Raising `instr_ready` for one cycle triggers exactly one new fetch.
- 3-wait-state RAM, `flush` with `flush_pc`=0x0200 asserted in the 2nd wait cycle → cycle completes, its data is never presented, and the next `instr_data` is RAM[0x0200] with `instr_pc`=0x0200.
- Flush on the same cycle as a pop and an ack → FIFO is empty next cycle and no stale word is ever presented.
- With `PROL16_FETCH_TIMEOUT_EN` and an ack that never arrives → `wb_cyc` drops after 15 cycles and `fetch_err`=1 persists until `rst`. Without the macro, `wb_cyc` stays asserted and `fetch_err`=0.
